// File: rtl/armleocpu_mem_arbiter_pkg.sv
// Shared command/response encodings and arbiter state definitions for the
// armleocpu memory-side fabric.
package armleocpu_mem_arbiter_pkg;

  localparam int unsigned CMD_WIDTH   = 3;
  localparam int unsigned RESP_WIDTH  = 3;
  localparam int unsigned BURST_WIDTH = 4;

  localparam logic [CMD_WIDTH-1:0] CMD_NONE  = 3'd0;
  localparam logic [CMD_WIDTH-1:0] CMD_READ  = 3'd1;
  localparam logic [CMD_WIDTH-1:0] CMD_WRITE = 3'd2;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY        = 3'd0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLAVEERROR  = 3'd1;
  localparam logic [RESP_WIDTH-1:0] RESP_DECODEERROR = 3'd2;
  localparam logic [RESP_WIDTH-1:0] RESP_UNKNOWNTYPE = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_D = 2'd1,
    ARB_GRANT_I = 2'd2
  } arb_state_t;

  localparam logic GRANT_SEL_D = 1'b0;
  localparam logic GRANT_SEL_I = 1'b1;

  // A burstcount of zero is a single-beat transfer.
  function automatic logic [BURST_WIDTH-1:0] burst_len(input logic [BURST_WIDTH-1:0] bc);
    return (bc == BURST_WIDTH'(0)) ? BURST_WIDTH'(1) : bc;
  endfunction

endpackage

// File: rtl/armleocpu_mem_arbiter.sv
// Merges the core's data and instruction ports onto one memory port, holding
// the grant for a full burst and routing completions to the granted master.
module armleocpu_mem_arbiter
  import armleocpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    d_transaction,
  input  logic [2:0]              d_cmd,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [3:0]              d_burstcount,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wbyte_enable,
  output logic                    d_transaction_done,
  output logic [2:0]              d_transaction_response,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  input  logic                    i_transaction,
  input  logic [2:0]              i_cmd,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [3:0]              i_burstcount,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wbyte_enable,
  output logic                    i_transaction_done,
  output logic [2:0]              i_transaction_response,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  output logic                    m_transaction,
  output logic [2:0]              m_cmd,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [3:0]              m_burstcount,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wbyte_enable,
  input  logic                    m_transaction_done,
  input  logic [2:0]              m_transaction_response,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  arb_state_t             state, next_state;
  logic [BURST_WIDTH-1:0] beat_cnt, beat_cnt_next;
  logic                   last_grant, last_grant_next;
  logic                   burst_end_c;

  // State, beat counter and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      beat_cnt   <= '0;
      last_grant <= GRANT_SEL_I;
    end else begin
      state      <= next_state;
      beat_cnt   <= beat_cnt_next;
      last_grant <= last_grant_next;
    end
  end

  // Final beat or any error response releases the grant.
  assign burst_end_c = m_transaction_done &&
                       ((beat_cnt == BURST_WIDTH'(1)) || (m_transaction_response != RESP_OKAY));

  // Arbitration, request mux and response demux.
  always_comb begin
    next_state             = state;
    beat_cnt_next          = beat_cnt;
    last_grant_next        = last_grant;
    m_transaction          = 1'b0;
    m_cmd                  = '0;
    m_address              = '0;
    m_burstcount           = '0;
    m_wdata                = '0;
    m_wbyte_enable         = '0;
    d_transaction_done     = 1'b0;
    d_transaction_response = '0;
    d_rdata                = '0;
    i_transaction_done     = 1'b0;
    i_transaction_response = '0;
    i_rdata                = '0;

    case (state)
      ARB_IDLE: begin
        // D wins a tie in fixed mode, or in round-robin when I went last.
        if (d_transaction &&
            (!i_transaction || (ARB_MODE != 32'd0) || (last_grant == GRANT_SEL_I))) begin
          next_state      = ARB_GRANT_D;
          beat_cnt_next   = burst_len(d_burstcount);
          last_grant_next = GRANT_SEL_D;
        end else if (i_transaction) begin
          next_state      = ARB_GRANT_I;
          beat_cnt_next   = burst_len(i_burstcount);
          last_grant_next = GRANT_SEL_I;
        end
      end

      ARB_GRANT_D: begin
        m_transaction          = d_transaction;
        m_cmd                  = d_cmd;
        m_address              = d_address;
        m_burstcount           = d_burstcount;
        m_wdata                = d_wdata;
        m_wbyte_enable         = d_wbyte_enable;
        d_transaction_done     = m_transaction_done;
        d_transaction_response = m_transaction_response;
        d_rdata                = m_rdata;
        if (m_transaction_done) beat_cnt_next = beat_cnt - BURST_WIDTH'(1);
        if (burst_end_c) next_state = ARB_IDLE;
      end

      ARB_GRANT_I: begin
        m_transaction          = i_transaction;
        m_cmd                  = i_cmd;
        m_address              = i_address;
        m_burstcount           = i_burstcount;
        m_wdata                = i_wdata;
        m_wbyte_enable         = i_wbyte_enable;
        i_transaction_done     = m_transaction_done;
        i_transaction_response = m_transaction_response;
        i_rdata                = m_rdata;
        if (m_transaction_done) beat_cnt_next = beat_cnt - BURST_WIDTH'(1);
        if (burst_end_c) next_state = ARB_IDLE;
      end

      default: next_state = ARB_IDLE;
    endcase
  end

endmodule
